// File: rtl/riscv_core_reorder_buffer_pkg.sv
// Shared types and sizing for the dual-issue reorder buffer and its operand-bypass search.
package riscv_core_reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_PTR_W  = $clog2(ROB_DEPTH);
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_REG_W  = 5;
  localparam int unsigned ROB_NUM_RD = 4;

  typedef logic [ROB_PTR_W-1:0]  rob_ptr_t;
  typedef logic [ROB_PTR_W:0]    rob_cnt_t;
  typedef logic [ROB_DATA_W-1:0] rob_data_t;
  typedef logic [ROB_REG_W-1:0]  rob_reg_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    logic      wen;
    rob_reg_t  dst;
    rob_data_t data;
  } rob_entry_t;

  // An entry may retire or forward once it holds its result.
  function automatic logic rob_entry_ready(input rob_entry_t e);
    return e.valid & e.done;
  endfunction

endpackage

// File: rtl/riscv_core_reorder_buffer_if.sv
// Issue/writeback/commit/operand-read bundle between the core pipeline and the reorder buffer.
interface riscv_core_reorder_buffer_if;
  import riscv_core_reorder_buffer_pkg::*;

  logic      rob_alloc_req_0, rob_alloc_req_1;
  logic      rob_alloc_wen_0, rob_alloc_wen_1;
  rob_reg_t  rob_alloc_dst_0, rob_alloc_dst_1;
  logic      rob_alloc_rdy;
  rob_ptr_t  rob_alloc_slot_0, rob_alloc_slot_1;

  logic      rob_fill_val_A, rob_fill_val_B;
  rob_ptr_t  rob_fill_slot_A, rob_fill_slot_B;
  rob_data_t rob_fill_data_A, rob_fill_data_B;

  logic      rob_commit_val_1, rob_commit_val_2;
  rob_reg_t  rob_commit_slot_1, rob_commit_slot_2;
  rob_data_t rob_commit_data_1, rob_commit_data_2;
  logic [1:0] rob_retire_cnt;
  logic      rob_full, rob_empty;

  rob_reg_t  rob_rd_reg_0, rob_rd_reg_1, rob_rd_reg_2, rob_rd_reg_3;
  logic      rob_rd_hit_0, rob_rd_hit_1, rob_rd_hit_2, rob_rd_hit_3;
  rob_data_t rob_rd_data_0, rob_rd_data_1, rob_rd_data_2, rob_rd_data_3;

  modport master (
    output rob_alloc_req_0, rob_alloc_req_1, rob_alloc_wen_0, rob_alloc_wen_1,
           rob_alloc_dst_0, rob_alloc_dst_1,
           rob_fill_val_A, rob_fill_val_B, rob_fill_slot_A, rob_fill_slot_B,
           rob_fill_data_A, rob_fill_data_B,
           rob_rd_reg_0, rob_rd_reg_1, rob_rd_reg_2, rob_rd_reg_3,
    input  rob_alloc_rdy, rob_alloc_slot_0, rob_alloc_slot_1,
           rob_commit_val_1, rob_commit_val_2, rob_commit_slot_1, rob_commit_slot_2,
           rob_commit_data_1, rob_commit_data_2, rob_retire_cnt, rob_full, rob_empty,
           rob_rd_hit_0, rob_rd_hit_1, rob_rd_hit_2, rob_rd_hit_3,
           rob_rd_data_0, rob_rd_data_1, rob_rd_data_2, rob_rd_data_3
  );

  modport slave (
    input  rob_alloc_req_0, rob_alloc_req_1, rob_alloc_wen_0, rob_alloc_wen_1,
           rob_alloc_dst_0, rob_alloc_dst_1,
           rob_fill_val_A, rob_fill_val_B, rob_fill_slot_A, rob_fill_slot_B,
           rob_fill_data_A, rob_fill_data_B,
           rob_rd_reg_0, rob_rd_reg_1, rob_rd_reg_2, rob_rd_reg_3,
    output rob_alloc_rdy, rob_alloc_slot_0, rob_alloc_slot_1,
           rob_commit_val_1, rob_commit_val_2, rob_commit_slot_1, rob_commit_slot_2,
           rob_commit_data_1, rob_commit_data_2, rob_retire_cnt, rob_full, rob_empty,
           rob_rd_hit_0, rob_rd_hit_1, rob_rd_hit_2, rob_rd_hit_3,
           rob_rd_data_0, rob_rd_data_1, rob_rd_data_2, rob_rd_data_3
  );

endinterface

// File: rtl/riscv_core_rob_search.sv
// Youngest-producer search: walks entries oldest->youngest from head so the last match wins.
module riscv_core_rob_search
  import riscv_core_reorder_buffer_pkg::*;
(
  input  rob_entry_t entries [ROB_DEPTH],
  input  rob_ptr_t   head,
  input  rob_reg_t   rd_reg,
  output logic       hit_c,
  output rob_data_t  data_c
);

  rob_ptr_t idx_c;

  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    idx_c  = head;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      idx_c = head + rob_ptr_t'(i);
      // x0 is hard-wired, so it never forwards.
      if ((rd_reg != '0) && rob_entry_ready(entries[idx_c]) && entries[idx_c].wen &&
          (entries[idx_c].dst == rd_reg)) begin
        hit_c  = 1'b1;
        data_c = entries[idx_c].data;
      end
    end
  end

endmodule

// File: rtl/riscv_core_reorder_buffer.sv
// 2-wide in-order-commit reorder buffer: dual alloc at issue, dual fill at W, up to 2 retires per cycle.
// Optional operand bypass search enabled by defining RISCV_ROB_BYP_READ_EN.
module riscv_core_reorder_buffer
  import riscv_core_reorder_buffer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  riscv_core_reorder_buffer_if.slave rob
);

  rob_entry_t entries_q [ROB_DEPTH];
  rob_ptr_t   head_q, tail_q;
  rob_cnt_t   count_q;

  logic       alloc_rdy_c;
  logic [1:0] nalloc_c;
  rob_ptr_t   head1_c, slot_1_c;
  logic       r1_c, r2_c;
  logic [1:0] retire_cnt_c;
  logic       fill_a_ok_c, fill_b_ok_c;
  logic       commit_val_1_c, commit_val_2_c;

  // Alloc grant, commit selection and fill legality, all from registered state.
  always_comb begin
    alloc_rdy_c  = (count_q <= rob_cnt_t'(ROB_DEPTH - 2));
    nalloc_c     = alloc_rdy_c ? (2'({1'b0, rob.rob_alloc_req_0}) + 2'({1'b0, rob.rob_alloc_req_1}))
                               : 2'd0;
    slot_1_c     = tail_q + rob_ptr_t'(rob.rob_alloc_req_0);
    head1_c      = head_q + rob_ptr_t'(1);
    r1_c         = rob_entry_ready(entries_q[head_q]);
    r2_c         = r1_c & rob_entry_ready(entries_q[head1_c]);
    retire_cnt_c = 2'({1'b0, r1_c}) + 2'({1'b0, r2_c});
    fill_a_ok_c  = rob.rob_fill_val_A & entries_q[rob.rob_fill_slot_A].valid &
                   ~entries_q[rob.rob_fill_slot_A].done;
    // A and B hitting the same slot is illegal; A's write is the one kept.
    fill_b_ok_c  = rob.rob_fill_val_B &
                   ~(rob.rob_fill_val_A && (rob.rob_fill_slot_A == rob.rob_fill_slot_B)) &
                   entries_q[rob.rob_fill_slot_B].valid & ~entries_q[rob.rob_fill_slot_B].done;
    commit_val_1_c = r1_c & entries_q[head_q].wen;
    commit_val_2_c = r2_c & entries_q[head1_c].wen;
  end

  assign rob.rob_alloc_rdy     = alloc_rdy_c;
  assign rob.rob_alloc_slot_0  = tail_q;
  assign rob.rob_alloc_slot_1  = slot_1_c;
  assign rob.rob_commit_val_1  = commit_val_1_c;
  assign rob.rob_commit_val_2  = commit_val_2_c;
  assign rob.rob_commit_slot_1 = commit_val_1_c ? entries_q[head_q].dst   : '0;
  assign rob.rob_commit_slot_2 = commit_val_2_c ? entries_q[head1_c].dst  : '0;
  assign rob.rob_commit_data_1 = commit_val_1_c ? entries_q[head_q].data  : '0;
  assign rob.rob_commit_data_2 = commit_val_2_c ? entries_q[head1_c].data : '0;
  assign rob.rob_retire_cnt    = retire_cnt_c;
  assign rob.rob_full          = (count_q == rob_cnt_t'(ROB_DEPTH));
  assign rob.rob_empty         = (count_q == '0);

  // Retire, fill and alloc touch disjoint entries: retire needs done, fill needs !done, alloc needs !valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) entries_q[rob_ptr_t'(i)] <= '0;
    end else begin
      if (r1_c) entries_q[head_q].valid  <= 1'b0;
      if (r2_c) entries_q[head1_c].valid <= 1'b0;
      if (fill_a_ok_c) begin
        entries_q[rob.rob_fill_slot_A].done <= 1'b1;
        entries_q[rob.rob_fill_slot_A].data <= rob.rob_fill_data_A;
      end
      if (fill_b_ok_c) begin
        entries_q[rob.rob_fill_slot_B].done <= 1'b1;
        entries_q[rob.rob_fill_slot_B].data <= rob.rob_fill_data_B;
      end
      if (alloc_rdy_c && rob.rob_alloc_req_0)
        entries_q[tail_q] <= '{valid: 1'b1, done: 1'b0, wen: rob.rob_alloc_wen_0,
                               dst: rob.rob_alloc_dst_0, data: '0};
      if (alloc_rdy_c && rob.rob_alloc_req_1)
        entries_q[slot_1_c] <= '{valid: 1'b1, done: 1'b0, wen: rob.rob_alloc_wen_1,
                                 dst: rob.rob_alloc_dst_1, data: '0};
      head_q  <= head_q + rob_ptr_t'(retire_cnt_c);
      tail_q  <= tail_q + rob_ptr_t'(nalloc_c);
      count_q <= count_q + rob_cnt_t'(nalloc_c) - rob_cnt_t'(retire_cnt_c);
    end
  end

  rob_reg_t  [ROB_NUM_RD-1:0] rd_reg_c;
  logic      [ROB_NUM_RD-1:0] rd_hit_c;
  rob_data_t [ROB_NUM_RD-1:0] rd_data_c;

  assign rd_reg_c = {rob.rob_rd_reg_3, rob.rob_rd_reg_2, rob.rob_rd_reg_1, rob.rob_rd_reg_0};

`ifdef RISCV_ROB_BYP_READ_EN
  for (genvar k = 0; k < ROB_NUM_RD; k++) begin : g_rd
    riscv_core_rob_search u_search (
      .entries (entries_q),
      .head    (head_q),
      .rd_reg  (rd_reg_c[k]),
      .hit_c   (rd_hit_c[k]),
      .data_c  (rd_data_c[k])
    );
  end
`else
  logic unused_rd_c;
  assign unused_rd_c = ^rd_reg_c;
  assign rd_hit_c    = '0;
  assign rd_data_c   = '0;
`endif

  assign rob.rob_rd_hit_0  = rd_hit_c[0];
  assign rob.rob_rd_hit_1  = rd_hit_c[1];
  assign rob.rob_rd_hit_2  = rd_hit_c[2];
  assign rob.rob_rd_hit_3  = rd_hit_c[3];
  assign rob.rob_rd_data_0 = rd_data_c[0];
  assign rob.rob_rd_data_1 = rd_data_c[1];
  assign rob.rob_rd_data_2 = rd_data_c[2];
  assign rob.rob_rd_data_3 = rd_data_c[3];

endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
// Directed bench for riscv_core_reorder_buffer; bypass expectations follow RISCV_ROB_BYP_READ_EN.
module tb_riscv_core_reorder_buffer;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  riscv_core_reorder_buffer_if rob_if ();

  riscv_core_reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rob_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    rob_if.rob_alloc_req_0 = 1'b0; rob_if.rob_alloc_req_1 = 1'b0;
    rob_if.rob_alloc_wen_0 = 1'b0; rob_if.rob_alloc_wen_1 = 1'b0;
    rob_if.rob_alloc_dst_0 = '0;   rob_if.rob_alloc_dst_1 = '0;
    rob_if.rob_fill_val_A  = 1'b0; rob_if.rob_fill_val_B  = 1'b0;
    rob_if.rob_fill_slot_A = '0;   rob_if.rob_fill_slot_B = '0;
    rob_if.rob_fill_data_A = '0;   rob_if.rob_fill_data_B = '0;
  endtask

  task automatic set_alloc(input logic r0, input logic w0, input logic [4:0] d0,
                           input logic r1, input logic w1, input logic [4:0] d1);
    rob_if.rob_alloc_req_0 = r0; rob_if.rob_alloc_wen_0 = w0; rob_if.rob_alloc_dst_0 = d0;
    rob_if.rob_alloc_req_1 = r1; rob_if.rob_alloc_wen_1 = w1; rob_if.rob_alloc_dst_1 = d1;
  endtask

  task automatic set_fill(input logic va, input logic [3:0] sa, input logic [31:0] da,
                          input logic vb, input logic [3:0] sb, input logic [31:0] db);
    rob_if.rob_fill_val_A = va; rob_if.rob_fill_slot_A = sa; rob_if.rob_fill_data_A = da;
    rob_if.rob_fill_val_B = vb; rob_if.rob_fill_slot_B = sb; rob_if.rob_fill_data_B = db;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int k = 0;
    while (rob_if.rob_empty !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 32'(rob_if.rob_empty), 32'd1);
  endtask

  // Churn pair i: slots, destinations and result data.
  function automatic logic [3:0]  ps(input int i); return 4'(1 + 2 * i); endfunction
  function automatic logic [4:0]  pd(input int i); return 5'(1 + (2 * i) % 30); endfunction
  function automatic logic [31:0] pv(input int i); return 32'(1000 + 2 * i); endfunction

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    clear_ops();
    rob_if.rob_rd_reg_0 = '0; rob_if.rob_rd_reg_1 = '0;
    rob_if.rob_rd_reg_2 = '0; rob_if.rob_rd_reg_3 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_empty",  32'(rob_if.rob_empty), 32'd1);
    check_eq("rst_full",   32'(rob_if.rob_full), 32'd0);
    check_eq("rst_rdy",    32'(rob_if.rob_alloc_rdy), 32'd1);
    check_eq("rst_cv1",    32'(rob_if.rob_commit_val_1), 32'd0);
    check_eq("rst_cv2",    32'(rob_if.rob_commit_val_2), 32'd0);
    check_eq("rst_retire", 32'(rob_if.rob_retire_cnt), 32'd0);
    check_eq("rst_hit0",   32'(rob_if.rob_rd_hit_0), 32'd0);
    check_eq("rst_data0",  rob_if.rob_rd_data_0, 32'd0);

    // Basic pair: fills out of order, both retire together.
    set_alloc(1, 1, 5'd5, 1, 1, 5'd6); #1;
    check_eq("t1_slot0", 32'(rob_if.rob_alloc_slot_0), 32'd0);
    check_eq("t1_slot1", 32'(rob_if.rob_alloc_slot_1), 32'd1);
    step(); clear_ops();
    check_eq("t1_nonempty", 32'(rob_if.rob_empty), 32'd0);
    set_fill(1, 4'd1, 32'd7, 0, 4'd0, 32'd0); step(); clear_ops(); #1;
    check_eq("t1_wait_rc", 32'(rob_if.rob_retire_cnt), 32'd0);
    check_eq("t1_wait_cv", 32'(rob_if.rob_commit_val_1), 32'd0);
    set_fill(0, 4'd0, 32'd0, 1, 4'd0, 32'd9); step(); clear_ops(); #1;
    check_eq("t1_cv1", 32'(rob_if.rob_commit_val_1), 32'd1);
    check_eq("t1_cv2", 32'(rob_if.rob_commit_val_2), 32'd1);
    check_eq("t1_cs1", 32'(rob_if.rob_commit_slot_1), 32'd5);
    check_eq("t1_cs2", 32'(rob_if.rob_commit_slot_2), 32'd6);
    check_eq("t1_cd1", rob_if.rob_commit_data_1, 32'd9);
    check_eq("t1_cd2", rob_if.rob_commit_data_2, 32'd7);
    check_eq("t1_rc",  32'(rob_if.rob_retire_cnt), 32'd2);
    step();
    check_eq("t1_empty", 32'(rob_if.rob_empty), 32'd1);

    // wen=0 entry retires without a commit write.
    set_alloc(1, 0, 5'd7, 0, 0, 5'd0); #1;
    check_eq("t4_slot0", 32'(rob_if.rob_alloc_slot_0), 32'd2);
    check_eq("t4_slot1", 32'(rob_if.rob_alloc_slot_1), 32'd3);
    step(); clear_ops();
    set_fill(1, 4'd2, 32'd3, 0, 4'd0, 32'd0); step(); clear_ops(); #1;
    check_eq("t4_rc",  32'(rob_if.rob_retire_cnt), 32'd1);
    check_eq("t4_cv1", 32'(rob_if.rob_commit_val_1), 32'd0);
    check_eq("t4_cs1", 32'(rob_if.rob_commit_slot_1), 32'd0);
    check_eq("t4_cd1", rob_if.rob_commit_data_1, 32'd0);
    step();
    check_eq("t4_empty", 32'(rob_if.rob_empty), 32'd1);

    // Fill to an unallocated slot is ignored.
    set_fill(1, 4'd8, 32'd77, 0, 4'd0, 32'd0); step(); clear_ops(); #1;
    check_eq("bad_fill_rc",    32'(rob_if.rob_retire_cnt), 32'd0);
    check_eq("bad_fill_empty", 32'(rob_if.rob_empty), 32'd1);

    // A and B to the same slot: A's data is kept.
    set_alloc(1, 1, 5'd9, 0, 0, 5'd0); step(); clear_ops();
    set_fill(1, 4'd3, 32'd55, 1, 4'd3, 32'd66); step(); clear_ops(); #1;
    check_eq("ab_cs1", 32'(rob_if.rob_commit_slot_1), 32'd9);
    check_eq("ab_cd1", rob_if.rob_commit_data_1, 32'd55);
    step();

    // Younger filled first must wait for the older entry.
    set_alloc(1, 1, 5'd10, 1, 1, 5'd11); step(); clear_ops();
    set_fill(0, 4'd0, 32'd0, 1, 4'd5, 32'd44); step(); clear_ops(); #1;
    check_eq("t2_hold_a", 32'(rob_if.rob_retire_cnt), 32'd0);
    step();
    check_eq("t2_hold_b", 32'(rob_if.rob_retire_cnt), 32'd0);
    set_fill(1, 4'd4, 32'd33, 0, 4'd0, 32'd0); step(); clear_ops(); #1;
    check_eq("t2_rc",  32'(rob_if.rob_retire_cnt), 32'd2);
    check_eq("t2_cs1", 32'(rob_if.rob_commit_slot_1), 32'd10);
    check_eq("t2_cd1", rob_if.rob_commit_data_1, 32'd33);
    check_eq("t2_cs2", 32'(rob_if.rob_commit_slot_2), 32'd11);
    check_eq("t2_cd2", rob_if.rob_commit_data_2, 32'd44);
    step();

    // Older done alone retires alone.
    set_alloc(1, 1, 5'd1, 1, 1, 5'd2); step(); clear_ops();
    set_fill(1, 4'd6, 32'd1, 0, 4'd0, 32'd0); step(); clear_ops(); #1;
    check_eq("t2p_rc",  32'(rob_if.rob_retire_cnt), 32'd1);
    check_eq("t2p_cv2", 32'(rob_if.rob_commit_val_2), 32'd0);
    step();
    set_fill(0, 4'd0, 32'd0, 1, 4'd7, 32'd2); step(); clear_ops(); #1;
    check_eq("t2p_rc2", 32'(rob_if.rob_retire_cnt), 32'd1);
    check_eq("t2p_cs1", 32'(rob_if.rob_commit_slot_1), 32'd2);
    check_eq("t2p_cd1", rob_if.rob_commit_data_1, 32'd2);
    step();

    // Bypass: slot8 x20 (unfilled, blocks retire), slot9 x3=11, slot10 x3=22.
    set_alloc(1, 1, 5'd20, 1, 1, 5'd3); step(); clear_ops();
    set_alloc(1, 1, 5'd3, 0, 0, 5'd0); step(); clear_ops();
    set_fill(1, 4'd9, 32'd11, 1, 4'd10, 32'd22); step(); clear_ops();
    rob_if.rob_rd_reg_0 = 5'd3; rob_if.rob_rd_reg_1 = 5'd0;
    rob_if.rob_rd_reg_2 = 5'd20; rob_if.rob_rd_reg_3 = 5'd3;
    #1;
    check_eq("t5_rc", 32'(rob_if.rob_retire_cnt), 32'd0);
`ifdef RISCV_ROB_BYP_READ_EN
    check_eq("t5_hit0",  32'(rob_if.rob_rd_hit_0), 32'd1);
    check_eq("t5_data0", rob_if.rob_rd_data_0, 32'd22);
    check_eq("t5_hit3",  32'(rob_if.rob_rd_hit_3), 32'd1);
    check_eq("t5_data3", rob_if.rob_rd_data_3, 32'd22);
`else
    check_eq("t5_hit0",  32'(rob_if.rob_rd_hit_0), 32'd0);
    check_eq("t5_data0", rob_if.rob_rd_data_0, 32'd0);
    check_eq("t5_hit3",  32'(rob_if.rob_rd_hit_3), 32'd0);
    check_eq("t5_data3", rob_if.rob_rd_data_3, 32'd0);
`endif
    check_eq("t5_hit1", 32'(rob_if.rob_rd_hit_1), 32'd0);
    check_eq("t5_hit2", 32'(rob_if.rob_rd_hit_2), 32'd0);

    // Reset with 7 entries in flight.
    set_alloc(1, 1, 5'd12, 1, 1, 5'd13); step();
    set_alloc(1, 1, 5'd14, 1, 1, 5'd15); step(); clear_ops();
    reset = 1'b1; step(); reset = 1'b0; #1;
    check_eq("t6_empty", 32'(rob_if.rob_empty), 32'd1);
    check_eq("t6_cv1",   32'(rob_if.rob_commit_val_1), 32'd0);
    check_eq("t6_rdy",   32'(rob_if.rob_alloc_rdy), 32'd1);
    check_eq("t6_rc",    32'(rob_if.rob_retire_cnt), 32'd0);
    check_eq("t6_hit0",  32'(rob_if.rob_rd_hit_0), 32'd0);
    check_eq("t6_slot0", 32'(rob_if.rob_alloc_slot_0), 32'd0);

    // Fill to 16 entries; full ROB retiring 2 must not grant alloc that cycle.
    for (int i = 0; i < 8; i++) begin
      set_alloc(1, 1, 5'(2 * i + 1), 1, 1, 5'(2 * i + 2));
      step();
    end
    clear_ops(); #1;
    check_eq("t3_full", 32'(rob_if.rob_full), 32'd1);
    check_eq("t3_rdy0", 32'(rob_if.rob_alloc_rdy), 32'd0);
    set_fill(1, 4'd0, 32'd200, 1, 4'd1, 32'd201); step(); clear_ops();
    set_alloc(1, 1, 5'd30, 1, 1, 5'd31); #1;
    check_eq("t3_rc",     32'(rob_if.rob_retire_cnt), 32'd2);
    check_eq("t3_rdy1",   32'(rob_if.rob_alloc_rdy), 32'd0);
    check_eq("t3_cd1",    rob_if.rob_commit_data_1, 32'd200);
    check_eq("t3_cd2",    rob_if.rob_commit_data_2, 32'd201);
    step(); clear_ops(); #1;
    check_eq("t3_rdy2",   32'(rob_if.rob_alloc_rdy), 32'd1);
    check_eq("t3_full2",  32'(rob_if.rob_full), 32'd0);
    check_eq("t3_tail",   32'(rob_if.rob_alloc_slot_0), 32'd0);
    for (int j = 2; j < 16; j += 2) begin
      set_fill(1, 4'(j), 32'(300 + j), 1, 4'(j + 1), 32'(301 + j));
      step();
    end
    clear_ops();
    wait_empty("t3_drain", 20);

    // Shift tail to an odd slot so churn pairs straddle the wrap.
    set_alloc(1, 0, 5'd0, 0, 0, 5'd0); step(); clear_ops();
    set_fill(1, 4'd0, 32'd0, 0, 4'd0, 32'd0); step(); clear_ops();
    wait_empty("t3_shift", 5);

    // 40 allocs: alloc pair i, fill pair i-1, see pair i-2 commit.
    for (int i = 0; i < 20; i++) begin
      set_alloc(1, 1, pd(i), 1, 1, 5'(pd(i) + 5'd1));
      if (i >= 1) set_fill(1, ps(i - 1), pv(i - 1), 1, 4'(ps(i - 1) + 4'd1), pv(i - 1) + 32'd1);
      #1;
      check_eq("wrap_slot0", 32'(rob_if.rob_alloc_slot_0), 32'(ps(i)));
      check_eq("wrap_slot1", 32'(rob_if.rob_alloc_slot_1), 32'(4'(ps(i) + 4'd1)));
      if (i >= 2) begin
        check_eq("wrap_rc",  32'(rob_if.rob_retire_cnt), 32'd2);
        check_eq("wrap_cs1", 32'(rob_if.rob_commit_slot_1), 32'(pd(i - 2)));
        check_eq("wrap_cd2", rob_if.rob_commit_data_2, pv(i - 2) + 32'd1);
      end
      step(); clear_ops();
    end
    set_fill(1, ps(19), pv(19), 1, 4'(ps(19) + 4'd1), pv(19) + 32'd1); #1;
    check_eq("wrap_t18_cs1", 32'(rob_if.rob_commit_slot_1), 32'(pd(18)));
    step(); clear_ops(); #1;
    check_eq("wrap_t19_rc",  32'(rob_if.rob_retire_cnt), 32'd2);
    check_eq("wrap_t19_cd1", rob_if.rob_commit_data_1, pv(19));
    check_eq("wrap_t19_cs2", 32'(rob_if.rob_commit_slot_2), 32'(5'(pd(19) + 5'd1)));
    wait_empty("wrap_drain", 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
